// File: rtl/uart_matrix_loader.sv
// rtl/uart_matrix_loader.sv - ASCII-hex matrix frame parser feeding the matrix multiplier
// Hunts for "MATX_TAG", gathers 32 hex bytes into a shadow copy and publishes A/B atomically.
module uart_matrix_loader #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  input  logic         rx_error,
  output logic [127:0] a_mat,
  output logic [127:0] b_mat,
  output logic         mat_valid,
  output logic         err,
  output logic         busy,
  output logic [5:0]   elem_cnt
);

  localparam logic [63:0]   TAG  = 64'h4D41_5458_5F54_4147;  // "MATX_TAG"
  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_HUNT,
    S_HI,
    S_LO,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state_q, state_d;
  // Only the last seven bytes are stored; the eighth is the byte arriving now.
  logic [55:0]    tag_q, tag_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [3:0]     hi_q, hi_d;
  logic [255:0]   shadow_q, shadow_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [127:0]   a_q, a_d;
  logic [127:0]   b_q, b_d;
  logic           mv_q, mv_d;
  logic           err_q, err_d;

  logic           is_hex;
  logic           is_ws;
  logic [3:0]     nib;
  logic [63:0]    tag_shift;
  logic [TW-1:0]  tcnt_inc;

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      nib = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      nib = rx_byte[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  assign is_ws     = (rx_byte == 8'h20) || (rx_byte == 8'h09) ||
                     (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign tag_shift = {tag_q, rx_byte};
  assign tcnt_inc  = tcnt_q + TW'(1);

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    shadow_d = shadow_q;
    tcnt_d   = '0;
    a_d      = a_q;
    b_d      = b_q;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_HUNT: begin
        if (rx_error) begin
          tag_d = '0;
        end else if (rx_valid) begin
          if (tag_shift == TAG) begin
            tag_d   = '0;
            cnt_d   = '0;
            state_d = S_HI;
          end else begin
            tag_d = tag_shift[55:0];
          end
        end
      end
      S_HI, S_LO: begin
        tcnt_d = tcnt_inc;
        if (rx_error) begin
          tcnt_d  = '0;
          state_d = S_ERR;
        end else if (rx_valid) begin
          tcnt_d = '0;
          if (state_q == S_HI) begin
            if (is_hex) begin
              hi_d    = nib;
              state_d = S_LO;
            end else if (!is_ws) begin
              state_d = S_ERR;
            end
          end else if (is_hex) begin
            // Element i lives at bits [255-8*i -: 8], i.e. base 8*(31-i).
            shadow_d[{~cnt_q[4:0], 3'b000} +: 8] = {hi_q, nib};
            cnt_d   = cnt_q + 6'd1;
            state_d = (cnt_q == 6'd31) ? S_DONE : S_HI;
          end else begin
            state_d = S_ERR;
          end
        end else if (tcnt_inc == TMAX) begin
          tcnt_d  = '0;
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        a_d     = shadow_q[255:128];
        b_d     = shadow_q[127:0];
        mv_d    = 1'b1;
        cnt_d   = '0;
        tag_d   = '0;
        state_d = S_HUNT;
      end
      S_ERR: begin
        err_d   = 1'b1;
        cnt_d   = '0;
        tag_d   = '0;
        state_d = S_HUNT;
      end
      default: begin
        cnt_d   = '0;
        tag_d   = '0;
        state_d = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HUNT;
      tag_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      shadow_q <= '0;
      tcnt_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      shadow_q <= shadow_d;
      tcnt_q   <= tcnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mv_q     <= mv_d;
      err_q    <= err_d;
    end
  end

  assign a_mat     = a_q;
  assign b_mat     = b_q;
  assign mat_valid = mv_q;
  assign err       = err_q;
  assign busy      = (state_q == S_HI) || (state_q == S_LO);
  assign elem_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// tb/tb_uart_matrix_loader.sv - table-driven scoreboard bench for uart_matrix_loader
module tb_uart_matrix_loader;

  localparam int TMO = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         rx_error;
  logic [127:0] a_mat;
  logic [127:0] b_mat;
  logic         mat_valid;
  logic         err;
  logic         busy;
  logic [5:0]   elem_cnt;

  uart_matrix_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_error  (rx_error),
    .a_mat     (a_mat),
    .b_mat     (b_mat),
    .mat_valid (mat_valid),
    .err       (err),
    .busy      (busy),
    .elem_cnt  (elem_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        prefix;
    logic [255:0] elems;
    int           style;
    int           bad_at;
    string        bad_str;
  } frame_t;

  typedef struct {
    bit           is_err;
    logic [127:0] a;
    logic [127:0] b;
  } exp_t;

  frame_t       frames [8];
  exp_t         sb [$];
  int           errors = 0;
  int           checks = 0;
  int           mv_seen = 0;
  int           mv_exp = 0;
  bit           err_flag = 0;
  logic [127:0] cur_a = '0;
  logic [127:0] cur_b = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (rst !== 1'b0) return;
    if (mat_valid === 1'b1 || err === 1'b1) begin
      if (err === 1'b1) err_flag = 1'b1;
      if (mat_valid === 1'b1) mv_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: mat_valid=%b err=%b required no pulse", mat_valid, err);
      end else begin
        e = sb.pop_front();
        check("pulse_err", err, e.is_err);
        check("pulse_valid", mat_valid, !e.is_err);
        check("a_mat", a_mat, e.a);
        check("b_mat", b_mat, e.b);
        check("busy_at_pulse", busy, 0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    idle($urandom_range(0, 2));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_gap(s[i]);
  endtask

  function automatic logic [7:0] hexch(input logic [3:0] n, input bit upper);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (upper ? 8'h41 : 8'h61) + 8'(n - 4'd10);
  endfunction

  // Sends n elements of value v; returns right after the last low nibble is consumed.
  task automatic send_elems(input int n, input logic [7:0] v);
    for (int k = 0; k < n; k++) begin
      send_gap(hexch(v[7:4], 1'b1));
      send_byte(hexch(v[3:0], 1'b1));
      if (k < n - 1) begin
        idle($urandom_range(0, 2));
        send_gap(8'h20);
      end
    end
  endtask

  task automatic send_frame(input int idx);
    frame_t     f;
    logic [7:0] el;
    bit         up;
    bit         ok;
    exp_t       e;
    f  = frames[idx];
    ok = (f.bad_at < 0);
    if (ok) begin
      cur_a = f.elems[255:128];
      cur_b = f.elems[127:0];
      mv_exp++;
    end
    e.is_err = !ok;
    e.a      = cur_a;
    e.b      = cur_b;
    sb.push_back(e);
    send_str(f.prefix);
    for (int k = 0; k < 32; k++) begin
      if (k == f.bad_at) begin
        send_str(f.bad_str);
        break;
      end
      el = f.elems[255-8*k -: 8];
      up = (f.style == 0) || (f.style == 2 && (k % 2) == 0);
      send_gap(hexch(el[7:4], up));
      send_byte(hexch(el[3:0], up));
      if (k < 31) begin
        idle($urandom_range(0, 2));
        if (f.style == 0) send_str((k % 4 == 3) ? "\015\012" : " ");
        if (f.style == 2) send_str((k % 4 == 3) ? "\012" : "\t");
      end
    end
    if (ok) begin
      check($sformatf("elem_cnt_done[%0d]", idx), elem_cnt, 32);
      check($sformatf("busy_done[%0d]", idx), busy, 0);
      idle(4);
    end else begin
      idle(4);
      check($sformatf("busy_after_err[%0d]", idx), busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    rx_byte  = 8'h00;

    frames[0] = '{prefix: "zzMATX_TAG\015\012",
                  elems: {128'h0102030405060708090A0B0C0D0E0F10, 128'h01000000000100000000010000000001},
                  style: 0, bad_at: -1, bad_str: ""};
    frames[1] = '{prefix: "MATX_MATX_TAG", elems: {256{1'b1}}, style: 1, bad_at: -1, bad_str: ""};
    frames[2] = '{prefix: "MATX_TAG ",
                  elems: 256'h0011223344556677_8899AABBCCDDEEFF_FEDCBA9876543210_0123456789ABCDEF,
                  style: 0, bad_at: 5, bad_str: "1G"};
    frames[3] = '{prefix: "MATX_TAG\012",
                  elems: 256'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0,
                  style: 2, bad_at: -1, bad_str: ""};
    frames[4] = '{prefix: "MATX_TAMATX_TAG\t", elems: {4{64'h00090A0F90A0F0FF}},
                  style: 2, bad_at: -1, bad_str: ""};
    frames[5] = '{prefix: "MATX_TAG",
                  elems: 256'h0011223344556677_8899AABBCCDDEEFF_FEDCBA9876543210_0123456789ABCDEF,
                  style: 0, bad_at: 3, bad_str: "4 5"};
    frames[6] = '{prefix: "MATX_TAG", elems: {32{8'h5A}}, style: 1, bad_at: 31, bad_str: "g"};
    frames[7] = '{prefix: "MATX_TAG", elems: {32{8'hC3}}, style: 0, bad_at: 0, bad_str: "Z"};

    idle(3);
    check("rst_a_mat", a_mat, 0);
    check("rst_b_mat", b_mat, 0);
    check("rst_mat_valid", mat_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_elem_cnt", elem_cnt, 0);
    rst = 1'b0;
    send_str("MATX_TA");
    check("partial_tag_busy", busy, 0);
    check("partial_tag_elem_cnt", elem_cnt, 0);

    for (int i = 0; i < 8; i++) send_frame(i);

    e = '{is_err: 1'b1, a: cur_a, b: cur_b};
    sb.push_back(e);
    send_str("MATX_TAG ");
    send_elems(10, 8'h5A);
    check("timeout_elem_cnt", elem_cnt, 10);
    check("timeout_busy", busy, 1);
    err_flag = 1'b0;
    n = 0;
    while (!err_flag && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!err_flag || (n - 1) < TMO + 1 || (n - 1) > TMO + 2) begin
      errors++;
      $display("FAIL timeout_latency: err seen=%0d after %0d cycles, required 51..52", err_flag, n - 1);
    end
    idle(3);

    e = '{is_err: 1'b1, a: cur_a, b: cur_b};
    sb.push_back(e);
    send_str("MATX_TAG\015\012");
    send_elems(20, 8'h77);
    idle(1);
    check("rx_error_pre_cnt", elem_cnt, 20);
    rx_byte  = 8'h33;
    rx_valid = 1'b1;
    rx_error = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
    idle(4);
    check("rx_error_busy", busy, 0);
    check("rx_error_elem_cnt", elem_cnt, 0);

    send_str("MATX_TAG ");
    send_elems(31, 8'h99);
    idle(1);
    send_gap(8'h20);
    send_gap(8'h39);
    rx_byte  = 8'h39;
    rx_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("midrst_a_mat", a_mat, 0);
    check("midrst_b_mat", b_mat, 0);
    check("midrst_busy", busy, 0);
    check("midrst_elem_cnt", elem_cnt, 0);
    check("midrst_mat_valid", mat_valid, 0);
    tick();
    rst   = 1'b0;
    cur_a = '0;
    cur_b = '0;
    idle(10);

    send_frame(0);
    idle(4);
    check("scoreboard_empty", sb.size(), 0);
    check("mat_valid_count", mv_seen, mv_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_matrix_loader.md
# uart_matrix_loader

Receive-side companion of the matrix-multiply datapath: parses an ASCII-hex matrix frame arriving byte-by-byte from the UART receiver and assembles two 4x4 matrices of 8-bit elements, A and B. It sits between the `uart` module's `received`/`rx_byte` outputs and the matrix multiplier. It replaces the SD-card block scan as the matrix source. The frame format matches the SD-card file: the tag `MATX_TAG`, then 32 hex byte values.

## Interface
- TIMEOUT_CYCLES, default 100_000_000: idle cycles allowed between bytes while a frame is in progress before it is aborted.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_valid  in  1  one-cycle strobe; rx_byte holds a valid byte (`uart.received`)
- rx_byte  in  8  received byte
- rx_error  in  1  framing error strobe from the UART (`uart.recv_error`)
- a_mat  out  128  matrix A, row-major; element i is a_mat[127-8*i -: 8]
- b_mat  out  128  matrix B, same packing
- mat_valid  out  1  one-cycle pulse; a_mat/b_mat were just updated
- err  out  1  one-cycle pulse; the current frame was aborted
- busy  out  1  high while a frame body is being parsed
- elem_cnt  out  6  number of elements accepted in the current frame, 0..32

## Operation
- States:
  - S_HUNT: search for the tag.
  - S_HI: expect the high nibble or whitespace.
  - S_LO: expect the low nibble.
  - S_DONE: commit the frame.
  - S_ERR: report the abort.
- S_HUNT:
  - Each rx_valid shifts rx_byte into a 64-bit tag register.
  - When the register equals "MATX_TAG" after the shift, go to S_HI with elem_cnt=0.
  - The tag register is cleared whenever S_HUNT is entered.
  - Overlapping input such as "MATX_MATX_TAG" must still match.
- Hex digits accepted: '0'-'9', 'A'-'F', 'a'-'f', mapped to 0..15.
- Whitespace: 0x20, 0x09, 0x0D, 0x0A.
- S_HI:
  - Whitespace is ignored.
  - A hex digit latches the high nibble and moves to S_LO.
  - Any other byte goes to S_ERR.
- S_LO:
  - A hex digit forms the element and writes it to shadow register index elem_cnt. Indices 0-15 go to A, 16-31 to B.
  - elem_cnt then increments.
  - If elem_cnt becomes 32, go to S_DONE; otherwise go to S_HI.
  - Any non-hex byte, including whitespace, goes to S_ERR.
- S_DONE (one cycle):
  - Copy the shadow registers to a_mat/b_mat.
  - Assert mat_valid.
  - Go to S_HUNT.
- S_ERR (one cycle):
  - Assert err.
  - Leave a_mat/b_mat unchanged; partial frames are never visible.
  - Go to S_HUNT.
- rx_error:
  - In S_HI or S_LO, it goes to S_ERR. This also applies when rx_error and rx_valid arrive in the same cycle; the byte is discarded.
  - In S_HUNT, it clears the tag register.
- Timeout:
  - A counter runs in S_HI/S_LO and clears on every rx_valid.
  - When it reaches TIMEOUT_CYCLES, go to S_ERR.
- busy = (state is S_HI or S_LO).
- elem_cnt holds 32 during S_DONE and returns to 0 on entry to S_HUNT.

## Timing
- Reset values:
  - state = S_HUNT
  - a_mat = 0, b_mat = 0
  - mat_valid = 0, err = 0, busy = 0, elem_cnt = 0
  - shadow registers, tag register and timeout counter = 0
- Byte latency:
  - A byte presented with rx_valid at edge k is consumed at edge k.
  - The state and elem_cnt updates are visible in cycle k+1.
- The 64th hex digit consumed at edge k gives:
  - S_DONE during cycle k+1.
  - a_mat/b_mat updated and mat_valid high in cycle k+2, for exactly one cycle.
- An error detected at edge k gives err high for exactly one cycle, in cycle k+2.
- S_DONE and S_ERR ignore rx_valid. A byte arriving in that cycle is dropped; a UART byte period of about 1000 cycles makes this harmless.
- Back-to-back rx_valid on consecutive cycles must be handled in every other state.
- rst in any state overrides everything in the same edge: outputs and state return to their reset values, and a_mat/b_mat go to 0.

## Test plan
- Reset value check:
  - Stimulus: assert rst for 3 cycles.
  - Required: all outputs 0, busy 0.
  - Stimulus: then send "MATX_TA".
  - Required: busy stays 0.
- Normal frame:
  - Stimulus: "zzMATX_TAG\r\n", then A = 01..10 (hex, space-separated, CRLF after each row), then B = identity (01 00 00 00 ...).
  - Required: exactly one mat_valid pulse.
  - Required: a_mat = 128'h0102030405060708090A0B0C0D0E0F10 and b_mat = 128'h01000000000100000000010000000001.
  - Required: elem_cnt = 32 in the S_DONE cycle.
- Lowercase and overlapping tag:
  - Stimulus: "MATX_MATX_TAG" followed by 32 copies of "ff".
  - Required: a_mat and b_mat all-ones, mat_valid pulse.
- Invalid character:
  - Stimulus: after a good frame, send a new tag, 5 elements, then "1G".
  - Required: one err pulse; a_mat/b_mat keep the previous values; busy drops.
  - Required: a following valid frame loads correctly.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 50; send the tag and 10 elements, then idle.
  - Required: err pulses 51-52 cycles after the last rx_valid; no mat_valid.
- rx_error and reset mid-frame:
  - Stimulus: rx_error together with rx_valid at element 20.
  - Required: err pulse.
  - Stimulus: restart the frame, then assert rst at element 31.
  - Required: everything returns to 0 and no mat_valid is produced.
